// File: rtl/gm_ht_nled_pwm.sv
// N-digit multiplexed 7-segment scanner with blanking gap, global PWM brightness and frame strobe.
// Optional per-digit blinking is compiled in when the BLINK_EN macro is defined.
module gm_ht_nled_pwm #(
  parameter int N_DIG        = 12,
  parameter int SLOT_TICKS   = 8,
  parameter int BLANK_TICKS  = 1,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 5
) (
  input  logic                 ckht,
  input  logic                 rst_n,
  input  logic                 ena1khz,
  input  logic [4*N_DIG-1:0]   digits,
  input  logic [N_DIG-1:0]     dp_in,
  input  logic [N_DIG-1:0]     ena_in,
  input  logic [BRIGHT_W-1:0]  brightness,
  input  logic [N_DIG-1:0]     blink,
  output logic [7:0]           sseg,
  output logic [N_DIG-1:0]     cathode,
  output logic                 frame_done
);

  localparam int IDX_W = $clog2(N_DIG);
  localparam int SC_W  = $clog2(SLOT_TICKS);
  localparam int BR_W  = $clog2(SLOT_TICKS + 1);
  localparam logic [31:0] BLANK_L  = 32'(BLANK_TICKS);
  localparam logic [31:0] ON_MAX_L = 32'(SLOT_TICKS - BLANK_TICKS);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      4'hF:    hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  logic [IDX_W-1:0] r_idx;
  logic [SC_W-1:0]  r_sc;
  logic [3:0]       r_nib;
  logic             r_dp;
  logic             r_ena;
  logic [BR_W-1:0]  r_bright;
  logic [7:0]       r_sseg;
  logic [N_DIG-1:0] r_cath;
  logic             r_frame_done;

  logic             w_slot_end;
  logic             w_frame_end;
  logic [IDX_W-1:0] w_idx_next;
  logic [BR_W-1:0]  w_bright_sat;
  logic             w_on;
  logic             w_dark;
  logic [7:0]       w_sseg;
  logic [N_DIG-1:0] w_cath;
  logic [N_DIG-1:0] w_one;

  assign w_one       = {{(N_DIG-1){1'b0}}, 1'b1};
  assign w_slot_end  = ena1khz && (r_sc == SC_W'(SLOT_TICKS - 1));
  assign w_frame_end = w_slot_end && (r_idx == IDX_W'(N_DIG - 1));
  assign w_idx_next  = (r_idx == IDX_W'(N_DIG - 1)) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
  assign w_on        = (32'(r_sc) >= BLANK_L) && (32'(r_sc) < BLANK_L + 32'(r_bright));

`ifdef BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);
  logic [FC_W-1:0] r_frame_cnt;
  logic            r_phase;
  logic            r_blink_lat;

  assign w_dark = ~r_ena | (r_blink_lat & r_phase);

  // Blink phase toggles every BLINK_FRAMES frames; blink request sampled with digit data.
  always_ff @(posedge ckht) begin
    if (!rst_n) begin
      r_frame_cnt <= {FC_W{1'b0}};
      r_phase     <= 1'b0;
      r_blink_lat <= 1'b0;
    end else begin
      if (w_frame_end) begin
        if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= {FC_W{1'b0}};
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
      end
      if (w_slot_end) begin
        r_blink_lat <= blink[w_idx_next];
      end
    end
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink;
  assign w_dark         = ~r_ena;
`endif

  // Brightness saturates at the number of non-blanked ticks in a slot.
  always_comb begin
    w_bright_sat = BR_W'(ON_MAX_L);
    if (32'(brightness) > ON_MAX_L) begin
      w_bright_sat = BR_W'(ON_MAX_L);
    end else begin
      w_bright_sat = BR_W'(brightness);
    end
  end

  // Next segment/cathode pattern from the current slot phase and latched digit data.
  always_comb begin
    w_sseg = 8'hFF;
    w_cath = {N_DIG{1'b1}};
    if (w_on) begin
      w_cath = ~(w_one << r_idx);
      if (w_dark) begin
        w_sseg = 8'hFF;
      end else begin
        w_sseg = {~r_dp, hex7(r_nib)};
      end
    end else begin
      w_sseg = 8'hFF;
      w_cath = {N_DIG{1'b1}};
    end
  end

  // Scan counters, slot-start data latch, frame-start brightness latch and output registers.
  always_ff @(posedge ckht) begin
    if (!rst_n) begin
      r_idx        <= {IDX_W{1'b0}};
      r_sc         <= {SC_W{1'b0}};
      r_nib        <= 4'h0;
      r_dp         <= 1'b0;
      r_ena        <= 1'b0;
      r_bright     <= BR_W'(ON_MAX_L);
      r_sseg       <= 8'hFF;
      r_cath       <= {N_DIG{1'b1}};
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (ena1khz) begin
        if (w_slot_end) begin
          r_sc  <= {SC_W{1'b0}};
          r_idx <= w_idx_next;
          r_nib <= digits[{w_idx_next, 2'b00} +: 4];
          r_dp  <= dp_in[w_idx_next];
          r_ena <= ena_in[w_idx_next];
        end else begin
          r_sc <= r_sc + SC_W'(1);
        end
        if (w_frame_end) begin
          r_bright <= w_bright_sat;
        end
      end
      r_sseg <= w_sseg;
      r_cath <= w_cath;
    end
  end

  assign sseg       = r_sseg;
  assign cathode    = r_cath;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_gm_ht_nled_pwm.sv
// Self-checking bench for gm_ht_nled_pwm at default parameters (12 digits, 8 ticks/slot, 1 blank tick).
module tb_gm_ht_nled_pwm;

  logic        ckht = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena1khz = 1'b0;
  logic [47:0] digits = 48'h0;
  logic [11:0] dp_in = 12'h0;
  logic [11:0] ena_in = 12'h0;
  logic [3:0]  brightness = 4'd7;
  logic [11:0] blink = 12'h0;
  logic [7:0]  sseg;
  logic [11:0] cathode;
  logic        frame_done;

  gm_ht_nled_pwm dut (
    .ckht(ckht), .rst_n(rst_n), .ena1khz(ena1khz), .digits(digits), .dp_in(dp_in),
    .ena_in(ena_in), .brightness(brightness), .blink(blink), .sseg(sseg),
    .cathode(cathode), .frame_done(frame_done)
  );

  always #5 ckht = ~ckht;

  int   n_checks = 0;
  int   n_errors = 0;
  int   t_cnt = 0;
  logic fd_a = 1'b0;
  logic fd_b = 1'b0;

  typedef struct {
    string       name;
    logic [7:0]  s;
    logic [11:0] c;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0]  b;
    logic [3:0]  nib;
    logic        dp;
    logic        en;
    int          sc;
    logic [7:0]  exp_s;
    logic [11:0] exp_c;
  } vec_t;
  vec_t vt[12];

  task automatic push_exp(input string nm, input logic [7:0] s, input logic [11:0] c);
    exp_t e;
    e.name = nm; e.s = s; e.c = c;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_empty: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if (sseg !== e.s || cathode !== e.c) begin
        n_errors++;
        $display("FAIL %s: got sseg=%h cathode=%h, want sseg=%h cathode=%h (t=%0d)",
                 e.name, sseg, cathode, e.s, e.c, t_cnt);
      end
    end
  endtask

  task automatic expect_out(input string nm, input logic [7:0] s, input logic [11:0] c);
    push_exp(nm, s, c);
    pop_check();
  endtask

  task automatic check_bit(input string nm, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b, want %b (t=%0d)", nm, got, want, t_cnt);
    end
  endtask

  // One scan tick; fd_a samples the cycle after the tick edge, fd_b the cycle after that.
  task automatic tick();
    @(negedge ckht); ena1khz = 1'b1;
    @(negedge ckht); ena1khz = 1'b0; fd_a = frame_done;
    @(negedge ckht); fd_b = frame_done;
    t_cnt++;
  endtask

  task automatic run_to(input int target);
    while (t_cnt < target) tick();
  endtask

  task automatic do_reset();
    @(negedge ckht); rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ckht);
      expect_out("reset_out", 8'hFF, 12'hFFF);
      check_bit("reset_fd", frame_done, 1'b0);
    end
    rst_n = 1'b1;
    t_cnt = 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse;
    vt[0]  = '{4'd7,  4'h5, 1'b1, 1'b1, 0, 8'hFF, 12'hFFF};
    vt[1]  = '{4'd7,  4'h5, 1'b1, 1'b1, 1, 8'h12, 12'hFF7};
    vt[2]  = '{4'd7,  4'h5, 1'b1, 1'b1, 7, 8'h12, 12'hFF7};
    vt[3]  = '{4'd7,  4'h5, 1'b1, 1'b0, 3, 8'hFF, 12'hFF7};
    vt[4]  = '{4'd3,  4'h8, 1'b0, 1'b1, 3, 8'h80, 12'hFF7};
    vt[5]  = '{4'd3,  4'h8, 1'b0, 1'b1, 4, 8'hFF, 12'hFFF};
    vt[6]  = '{4'd15, 4'hA, 1'b0, 1'b1, 7, 8'h88, 12'hFF7};
    vt[7]  = '{4'd0,  4'h5, 1'b1, 1'b1, 1, 8'hFF, 12'hFFF};
    vt[8]  = '{4'd1,  4'hC, 1'b1, 1'b1, 1, 8'h46, 12'hFF7};
    vt[9]  = '{4'd1,  4'hC, 1'b1, 1'b1, 2, 8'hFF, 12'hFFF};
    vt[10] = '{4'd7,  4'hF, 1'b0, 1'b1, 4, 8'h8E, 12'hFF7};
    vt[11] = '{4'd7,  4'h0, 1'b1, 1'b1, 6, 8'h40, 12'hFF7};

    // Table: digit 3 in frame 1, after brightness has been latched at the first frame boundary.
    for (int i = 0; i < 12; i++) begin
      brightness = vt[i].b;
      digits = 48'h0; digits[15:12] = vt[i].nib;
      dp_in = 12'h0;  dp_in[3] = vt[i].dp;
      ena_in = 12'h0; ena_in[3] = vt[i].en;
      do_reset();
      run_to(96 + 24 + vt[i].sc);
      push_exp($sformatf("vec%0d", i), vt[i].exp_s, vt[i].exp_c);
      pop_check();
    end

    // Brightness change 3 -> 7 mid-frame applies only from the next frame.
    brightness = 4'd3; digits = 48'h0; digits[15:12] = 4'h5;
    dp_in = 12'h008; ena_in = 12'h008;
    do_reset();
    run_to(96);
    brightness = 4'd7;
    run_to(96 + 27);  expect_out("bright3_lit",  8'h12, 12'hFF7);
    run_to(96 + 29);  expect_out("bright3_dark", 8'hFF, 12'hFFF);
    run_to(192 + 29); expect_out("bright7_lit",  8'h12, 12'hFF7);

    // First slot of digit 0 dark; mid-slot data change held until next slot.
    brightness = 4'd7; digits = 48'h0; digits[3:0] = 4'h1; digits[15:12] = 4'h5;
    dp_in = 12'h008; ena_in = 12'hFFF;
    do_reset();
    run_to(1);  expect_out("first_slot_dark", 8'hFF, 12'hFFE);
    run_to(26); expect_out("slot3_before", 8'h12, 12'hFF7);
    digits[15:12] = 4'h8; dp_in[3] = 1'b0;
    run_to(27); expect_out("mid_slot_hold", 8'h12, 12'hFF7);
    run_to(97); expect_out("dig0_frame1", 8'hF9, 12'hFFE);
    run_to(123); expect_out("slot3_updated", 8'h80, 12'hFF7);

    // Free run: frame_done one cycle wide every 96 ticks.
    do_reset();
    npulse = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      check_bit("fd_pulse", fd_a, (t_cnt % 96) == 0);
      check_bit("fd_width", fd_b, 1'b0);
      if (fd_a) npulse++;
    end
    n_checks++;
    if (npulse != 3) begin
      n_errors++;
      $display("FAIL fd_count: got %0d pulses, want 3", npulse);
    end

    // Reset in slot 6 sc 4; scanning restarts at digit 0.
    digits = 48'h0; dp_in = 12'h008; ena_in = 12'hFFF; brightness = 4'd7;
    do_reset();
    run_to(52); expect_out("slot6_lit", 8'hC0, 12'hFBF);
    @(negedge ckht); rst_n = 1'b0;
    @(negedge ckht);
    expect_out("midslot_reset", 8'hFF, 12'hFFF);
    check_bit("midslot_reset_fd", frame_done, 1'b0);
    rst_n = 1'b1; t_cnt = 0;
    tick(); expect_out("after_reset_dig0", 8'hFF, 12'hFFE);

    // Blink on digit 0 across 15 frames; digit 1 never blinks.
    digits = 48'h0; digits[3:0] = 4'h1; digits[7:4] = 4'h2;
    dp_in = 12'h000; ena_in = 12'hFFF; blink = 12'h001; brightness = 4'd7;
    do_reset();
    for (int f = 0; f < 15; f++) begin
      run_to(f * 96 + 1);
      if (f == 0) begin
        expect_out("blink_d0_f0", 8'hFF, 12'hFFE);
`ifdef BLINK_EN
      end else if (f >= 5 && f <= 9) begin
        expect_out($sformatf("blink_d0_dark_f%0d", f), 8'hFF, 12'hFFE);
`endif
      end else begin
        expect_out($sformatf("blink_d0_lit_f%0d", f), 8'hF9, 12'hFFE);
      end
      run_to(f * 96 + 9);
      expect_out($sformatf("blink_d1_f%0d", f), 8'hA4, 12'hFFD);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
